// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM state encodings
// and the default operand width.
package div_pkg;

    localparam int unsigned DIV_SIZE = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/signed_div_iter_if.sv
// Request/result bundle of the iterative signed divider.
interface signed_div_iter_if #(
    parameter int unsigned div_size = div_pkg::DIV_SIZE
);

    logic                start;
    logic [div_size-1:0] A_in;
    logic [div_size-1:0] B_in;
    logic                busy;
    logic                done;
    logic [div_size-1:0] Q;
    logic [div_size-1:0] R;
    logic                div_by_zero;
    logic                ovf;

    modport master (
        output start, A_in, B_in,
        input  busy, done, Q, R, div_by_zero, ovf
    );

    modport slave (
        input  start, A_in, B_in,
        output busy, done, Q, R, div_by_zero, ovf
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step on magnitudes: shift {P, Qsh} left,
// trial-subtract |B| and keep the difference only when it is non-negative.
module div_step #(
    parameter int unsigned div_size = 32
) (
    input  logic [div_size:0]   p,
    input  logic [div_size-1:0] qsh,
    input  logic [div_size-1:0] mag_b,
    output logic [div_size:0]   p_next,
    output logic [div_size-1:0] qsh_next
);

    localparam int unsigned PW = div_size + 2;

    logic [PW-1:0] p_sh;
    logic [PW-1:0] t;

    always_comb begin
        // One spare bit above P keeps the trial difference's sign unambiguous
        p_sh     = {p, qsh[div_size-1]};
        t        = p_sh - PW'(mag_b);
        p_next   = t[PW-1] ? p_sh[div_size:0] : t[div_size:0];
        qsh_next = {qsh[div_size-2:0], ~t[PW-1]};
    end

endmodule

// File: rtl/signed_div_iter.sv
// Iterative signed divider: magnitude restoring division, one quotient bit per
// clock, followed by a sign fix-up with divide-by-zero and MIN/-1 overrides.
module signed_div_iter
    import div_pkg::*;
#(
    parameter int unsigned div_size = DIV_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    signed_div_iter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(div_size);
    localparam logic [div_size-1:0] MIN_VAL = {1'b1, {(div_size-1){1'b0}}};

    state_t              state_q, state_d;
    logic [div_size-1:0] a_q, a_d, b_q, b_d;
    logic [div_size:0]   p_q, p_d;
    logic [div_size-1:0] qsh_q, qsh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic [div_size-1:0] q_q, q_d, r_q, r_d;
    logic                dbz_q, dbz_d, ovf_q, ovf_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic [div_size-1:0] mag_a, mag_b;
    logic [div_size:0]   step_p;
    logic [div_size-1:0] step_qsh;

    assign mag_a = a_q[div_size-1] ? div_size'(-a_q) : a_q;
    assign mag_b = b_q[div_size-1] ? div_size'(-b_q) : b_q;

    div_step #(.div_size(div_size)) u_step (
        .p        (p_q),
        .qsh      (qsh_q),
        .mag_b    (mag_b),
        .p_next   (step_p),
        .qsh_next (step_qsh)
    );

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        qsh_d   = qsh_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A_in;
                    b_d     = bus.B_in;
                    busy_d  = 1'b1;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                sa_d    = a_q[div_size-1];
                sb_d    = b_q[div_size-1];
                p_d     = '0;
                qsh_d   = mag_a;
                cnt_d   = CNT_W'(div_size - 1);
                state_d = ST_ITER;
            end
            ST_ITER: begin
                p_d   = step_p;
                qsh_d = step_qsh;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                dbz_d = 1'b0;
                ovf_d = 1'b0;
                if (b_q == '0) begin
                    q_d   = '1;
                    r_d   = a_q;
                    dbz_d = 1'b1;
                end else if ((a_q == MIN_VAL) && (b_q == '1)) begin
                    q_d   = MIN_VAL;
                    r_d   = '0;
                    ovf_d = 1'b1;
                end else begin
                    q_d = (sa_q ^ sb_q) ? div_size'(-qsh_q) : qsh_q;
                    r_d = sa_q ? div_size'(-p_q[div_size-1:0]) : p_q[div_size-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register update; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            qsh_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            qsh_q   <= qsh_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_signed_div_iter.sv
// Self-checking bench for signed_div_iter: directed sign/boundary/timing cases
// plus randomised operands against a truncating-division reference model.
module tb_signed_div_iter;

    localparam int unsigned W     = 32;
    localparam int          LAT   = W + 2;
    localparam int          N_RND = 1500;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    signed_div_iter_if #(.div_size(W)) bus ();

    signed_div_iter #(.div_size(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division with the two documented overrides
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov);
        int sa;
        int sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (a == 32'h8000_0000 && sb == -1) begin
            q  = 32'h8000_0000;
            r  = 32'd0;
            ov = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.A_in  = a;
        bus.B_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.done && cycles < LAT + 20);
    endtask

    task automatic expect_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input bit full);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          cyc;
        model(a, b, q, r, dz, ov);
        wait_done(cyc);
        check_eq({tag, ".Q"}, bus.Q, q);
        check_eq({tag, ".R"}, bus.R, r);
        check_eq({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(dz));
        check_eq({tag, ".ovf"}, 32'(bus.ovf), 32'(ov));
        if (full) begin
            check_eq({tag, ".latency"}, cyc, LAT);
            check_eq({tag, ".busy_low"}, 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic count_dones(input int ncyc, output int n);
        n = 0;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            if (bus.done) n++;
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5, 6:    v = 32'($urandom_range(0, 40)) - 32'd20;
            7:       v = 32'($urandom_range(0, 65535)) - 32'd32768;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] b;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A_in  = '0;
        bus.B_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.busy", 32'(bus.busy), 32'd0);
        check_eq("rst.done", 32'(bus.done), 32'd0);
        check_eq("rst.Q", bus.Q, 32'd0);
        check_eq("rst.R", bus.R, 32'd0);
        check_eq("rst.dbz", 32'(bus.div_by_zero), 32'd0);
        check_eq("rst.ovf", 32'(bus.ovf), 32'd0);

        // Reset wins over a simultaneous start
        bus.start = 1'b1;
        bus.A_in  = 32'd50;
        bus.B_in  = 32'd5;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check_eq("rst_start.busy", 32'(bus.busy), 32'd0);
        count_dones(LAT + 6, n);
        check_eq("rst_start.dones", n, 0);

        launch(32'd100, 32'd7);
        check_eq("busy_rise", 32'(bus.busy), 32'd1);
        expect_op("p100_7", 32'd100, 32'd7, 1'b1);
        check_eq("p100_7.Qconst", bus.Q, 32'd14);
        check_eq("p100_7.Rconst", bus.R, 32'd2);
        launch(-100, 32'd7);
        expect_op("m100_7", -100, 32'd7, 1'b1);
        check_eq("m100_7.Qconst", bus.Q, -14);
        check_eq("m100_7.Rconst", bus.R, -2);
        launch(32'd100, -7);
        expect_op("p100_m7", 32'd100, -7, 1'b1);

        launch(32'h8000_0000, 32'hFFFF_FFFF);
        expect_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_eq("min_m1.ovfconst", 32'(bus.ovf), 32'd1);
        launch(32'h8000_0000, 32'd1);
        expect_op("min_p1", 32'h8000_0000, 32'd1, 1'b1);

        launch(32'd5, 32'd0);
        expect_op("div0", 32'd5, 32'd0, 1'b1);
        check_eq("div0.Qconst", bus.Q, 32'hFFFF_FFFF);
        // Back-to-back: next start lands in the done cycle
        launch(32'd9, 32'd3);
        expect_op("after_div0", 32'd9, 32'd3, 1'b1);
        launch(-12345, 32'd77);
        expect_op("b2b", -12345, 32'd77, 1'b1);

        // A start pulse while busy must be ignored
        launch(32'd1000, -3);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.A_in  = 32'd7;
        bus.B_in  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        expect_op("ign_start", 32'd1000, -3, 1'b0);
        count_dones(2 * LAT, n);
        check_eq("ign_start.extra_dones", n, 0);

        // Reset during the tenth cycle of an operation
        launch(32'd1234567, 32'd89);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid_rst.busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst.Q", bus.Q, 32'd0);
        check_eq("mid_rst.R", bus.R, 32'd0);
        count_dones(LAT + 6, n);
        check_eq("mid_rst.dones", n, 0);
        launch(32'd49, -5);
        expect_op("p49_m5", 32'd49, -5, 1'b1);
        check_eq("p49_m5.Qconst", bus.Q, -9);
        check_eq("p49_m5.Rconst", bus.R, 32'd4);

        for (int i = 0; i < N_RND; i++) begin
            a = pick();
            b = pick();
            launch(a, b);
            expect_op($sformatf("rnd%0d", i), a, b, (i % 50) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
